prescaled_counter: RTL and testbench
====================================

PRESCALED_COUNTER -- requirements
Module: prescaled_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 5: counter width in bits.
REQ-002 SHALL have parameter PRESET, default 19: reload/terminal value; legal range 0..2^WIDTH-1.
REQ-003 SHALL have parameter DIV, default 10_000_000: prescale ratio in CLOCK_50 cycles per count step; legal range DIV>=1.
REQ-004 SHALL have port CLOCK_50  input  1  system clock; all state changes on its rising edge.
REQ-005 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port SW  input  4  SW[0] load, SW[1] enable, SW[2] direction (1 up, 0 down), SW[3] mode (1 one-shot, 0 wrap).
REQ-007 SHALL have port LEDR  output  WIDTH  current count, registered.
REQ-008 SHALL have port TC  output  1  terminal-count pulse, registered, one CLOCK_50 cycle wide.
REQ-009 SHALL have port DONE  output  1  one-shot completion flag, registered, level.

Function
REQ-010 SHALL use a single clock domain; no derived or gated clock; step timing SHALL use an internal one-cycle tick enable.
REQ-011 Prescaler SHALL count 0..DIV-1 while SW[1]=1; tick SHALL assert for the one cycle in which prescaler = DIV-1, with the prescaler returning to 0 on the next cycle.
REQ-012 Prescaler SHALL be held at 0 while SW[1]=0 or SW[0]=1; with DIV=1, tick SHALL assert every enabled cycle.
REQ-013 Prescaler width SHALL be derived from DIV (ceil log2, minimum 1); no integer-sized counters.
REQ-014 Load (SW[0]=1) SHALL be synchronous and take priority over tick: LEDR <= PRESET if SW[2]=0, else 0; DONE <= 0; TC <= 0.
REQ-015 Down step (tick, SW[2]=0, DONE=0): LEDR>0 -> LEDR-1; LEDR=0 -> terminal event.
REQ-016 Up step (tick, SW[2]=1, DONE=0): LEDR<PRESET -> LEDR+1; LEDR>=PRESET -> terminal event.
REQ-017 Terminal event, wrap mode (SW[3]=0): down reloads PRESET, up reloads 0; TC SHALL be 1 in the cycle LEDR shows the reloaded value.
REQ-018 Terminal event, one-shot mode (SW[3]=1): LEDR holds; DONE <= 1; TC SHALL pulse once in the same cycle DONE rises.
REQ-019 While DONE=1, LEDR and TC SHALL be frozen (TC=0) regardless of tick, SW[2] or SW[3]; only load or RESET SHALL clear DONE.
REQ-020 A direction change mid-count SHALL continue from the current LEDR with no reload; a count above PRESET in up mode SHALL be treated as terminal.
REQ-021 Arithmetic SHALL be WIDTH-bit, with no overflow beyond the rules above; TC SHALL be 0 on every non-terminal cycle.
REQ-022 Deasserting SW[1] mid-interval SHALL discard the partial prescale count; LEDR SHALL hold.

Reset
REQ-023 RESET=1 SHALL immediately, without a clock edge, force LEDR=PRESET, prescaler=0, TC=0, DONE=0.
REQ-024 After RESET deasserts, the first tick SHALL occur DIV enabled cycles later.
REQ-025 RESET asserted mid-interval or during a TC pulse SHALL abort it; no TC SHALL appear after release until a new terminal event.

Verification (bench parameters WIDTH=5, PRESET=19, DIV=4 unless stated)
REQ-026 Reset then SW=4'b0010 for 80 cycles -> LEDR 19,18,..., one step per 4 cycles; LEDR=0 at cycle 76; TC high the cycle LEDR returns to 19 at cycle 80.
REQ-027 SW=4'b1010 (one-shot down) from 19 -> LEDR reaches 0 and holds; DONE=1 with a single TC pulse at cycle 80; further cycles keep LEDR=0, TC=0; SW[0] pulse -> LEDR=19, DONE=0.
REQ-028 SW=4'b0111 (load, up) for one cycle, then 4'b0110 -> LEDR 0..19, then wrap to 0 with TC; reversing SW[2] at LEDR=7 -> next step 6.
REQ-029 Load and tick in the same cycle with LEDR=5, down mode -> LEDR=19, no decrement, TC=0.
REQ-030 RESET pulse asynchronous to CLOCK_50 at LEDR=3 -> LEDR=19 before the next edge; SW[1] toggled low at prescaler=2 -> no step, restart from 0.
REQ-031 DIV=1, PRESET=0, down wrap -> TC=1 and LEDR=0 every enabled cycle.

Source files
------------

// File: rtl/prescaled_counter.sv
// Counter stepped by an internal prescaler tick: load, up/down, and wrap or one-shot
// terminal handling. LEDR, TC and DONE all come straight from registers.
module prescaled_counter #(
    parameter int WIDTH  = 5,
    parameter int PRESET = 19,
    parameter int DIV    = 10_000_000
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    input  logic [3:0]       SW,
    output logic [WIDTH-1:0] LEDR,
    output logic             TC,
    output logic             DONE
);

    localparam int                PS_W       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PS_W-1:0]   PS_LAST    = PS_W'(DIV - 1);
    localparam logic [PS_W-1:0]   PS_ONE     = PS_W'(1);
    localparam logic [PS_W-1:0]   PS_ZERO    = PS_W'(0);
    localparam logic [WIDTH-1:0]  CNT_PRESET = WIDTH'(PRESET);
    localparam logic [WIDTH-1:0]  CNT_ZERO   = WIDTH'(0);
    localparam logic [WIDTH-1:0]  CNT_ONE    = WIDTH'(1);

    logic             load_s;
    logic             enable_s;
    logic             up_s;
    logic             oneshot_s;
    logic             tick_s;
    logic             at_end_s;
    logic [PS_W-1:0]  presc_r;
    logic [PS_W-1:0]  presc_nxt_s;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_nxt_s;
    logic             tc_r;
    logic             tc_nxt_s;
    logic             done_r;
    logic             done_nxt_s;

    assign load_s    = SW[0];
    assign enable_s  = SW[1];
    assign up_s      = SW[2];
    assign oneshot_s = SW[3];
    assign tick_s    = enable_s && (presc_r == PS_LAST);
    // Up mode treats any value at or above PRESET as terminal, so out-of-range counts never overflow.
    assign at_end_s  = up_s ? (count_r >= CNT_PRESET) : (count_r == CNT_ZERO);

    // Prescaler next value: a partial interval is discarded whenever counting is paused or loaded.
    always_comb begin
        presc_nxt_s = presc_r;
        if (load_s || !enable_s) begin
            presc_nxt_s = PS_ZERO;
        end else if (tick_s) begin
            presc_nxt_s = PS_ZERO;
        end else begin
            presc_nxt_s = presc_r + PS_ONE;
        end
    end

    // Counter, terminal pulse and one-shot flag next values; load outranks a coincident tick.
    always_comb begin
        count_nxt_s = count_r;
        tc_nxt_s    = 1'b0;
        done_nxt_s  = done_r;
        if (load_s) begin
            count_nxt_s = up_s ? CNT_ZERO : CNT_PRESET;
            done_nxt_s  = 1'b0;
        end else if (tick_s && !done_r) begin
            if (!at_end_s) begin
                count_nxt_s = up_s ? (count_r + CNT_ONE) : (count_r - CNT_ONE);
            end else if (oneshot_s) begin
                done_nxt_s = 1'b1;
                tc_nxt_s   = 1'b1;
            end else begin
                count_nxt_s = up_s ? CNT_ZERO : CNT_PRESET;
                tc_nxt_s    = 1'b1;
            end
        end else begin
            count_nxt_s = count_r;
            done_nxt_s  = done_r;
        end
    end

    // State registers with asynchronous reset to the preset value.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            presc_r <= PS_ZERO;
            count_r <= CNT_PRESET;
            tc_r    <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            presc_r <= presc_nxt_s;
            count_r <= count_nxt_s;
            tc_r    <= tc_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    assign LEDR = count_r;
    assign TC   = tc_r;
    assign DONE = done_r;

endmodule

// File: tb/tb_prescaled_counter.sv
// Directed and randomized checks of prescaled_counter against a rule-level reference model;
// a second instance covers the DIV=1, PRESET=0 corner.
module tb_prescaled_counter;

    localparam int WIDTH  = 5;
    localparam int PRESET = 19;
    localparam int DIV    = 4;

    logic             clk;
    logic             rst;
    logic [3:0]       sw;
    logic [WIDTH-1:0] ledr_a;
    logic             tc_a;
    logic             done_a;
    logic [WIDTH-1:0] ledr_b;
    logic             tc_b;
    logic             done_b;

    int checks;
    int errors;
    int tc_seen;

    // reference model state
    int m_cnt;
    int m_run;
    int m_done;
    int m_tc;

    prescaled_counter #(.WIDTH(WIDTH), .PRESET(PRESET), .DIV(DIV)) dut_a (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .SW       (sw),
        .LEDR     (ledr_a),
        .TC       (tc_a),
        .DONE     (done_a)
    );

    prescaled_counter #(.WIDTH(WIDTH), .PRESET(0), .DIV(1)) dut_b (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .SW       (sw),
        .LEDR     (ledr_b),
        .TC       (tc_b),
        .DONE     (done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt  = PRESET;
        m_run  = 0;
        m_done = 0;
        m_tc   = 0;
    endtask

    // A step happens on every DIV-th consecutive enabled, non-load cycle.
    task automatic model_edge(input logic [3:0] s);
        bit tick;
        bit term;
        tick = s[1] && ((m_run % DIV) == DIV - 1);
        if (s[0] || !s[1]) m_run = 0;
        else m_run = m_run + 1;
        m_tc = 0;
        if (s[0]) begin
            m_cnt  = s[2] ? 0 : PRESET;
            m_done = 0;
        end else if (tick && m_done == 0) begin
            term = s[2] ? (m_cnt >= PRESET) : (m_cnt == 0);
            if (!term) m_cnt = s[2] ? m_cnt + 1 : m_cnt - 1;
            else if (s[3]) begin
                m_done = 1;
                m_tc   = 1;
            end else begin
                m_cnt = s[2] ? 0 : PRESET;
                m_tc  = 1;
            end
        end
    endtask

    task automatic cyc(input logic [3:0] s);
        @(negedge clk);
        sw = s;
        @(posedge clk);
        model_edge(s);
        #1;
        if (tc_a === 1'b1) tc_seen++;
        chk("ledr", 32'(ledr_a), 32'(m_cnt));
        chk("tc", 32'(tc_a), 32'(m_tc));
        chk("done", 32'(done_a), 32'(m_done));
    endtask

    task automatic cycn(input logic [3:0] s, input int n);
        for (int i = 0; i < n; i++) cyc(s);
    endtask

    // Asynchronous reset pulse placed between clock edges; outputs must change without an edge.
    task automatic async_reset();
        #1 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_ledr", 32'(ledr_a), 32'(PRESET));
        chk("rst_tc", 32'(tc_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        #1 rst = 1'b0;
    endtask

    initial begin
        logic [3:0] rs;
        checks  = 0;
        errors  = 0;
        tc_seen = 0;
        rst     = 1'b0;
        sw      = 4'b0000;
        model_reset();
        async_reset();

        // down wrap over a full period
        cycn(4'b0010, 76);
        chk("down_zero", 32'(ledr_a), 32'd0);
        cycn(4'b0010, 4);
        chk("down_wrap_ledr", 32'(ledr_a), 32'd19);
        chk("down_wrap_tc", 32'(tc_a), 32'd1);
        chk("down_tc_count", 32'(tc_seen), 32'd1);

        // one-shot down
        cyc(4'b0011);
        tc_seen = 0;
        cycn(4'b1010, 80);
        chk("oneshot_done", 32'(done_a), 32'd1);
        chk("oneshot_ledr", 32'(ledr_a), 32'd0);
        cycn(4'b1010, 8);
        cycn(4'b1110, 8);
        chk("oneshot_tc_count", 32'(tc_seen), 32'd1);
        cyc(4'b1011);
        chk("oneshot_reload", 32'(ledr_a), 32'd19);
        chk("oneshot_clear", 32'(done_a), 32'd0);

        // up wrap, then direction reversal at 7
        cyc(4'b0111);
        chk("up_load", 32'(ledr_a), 32'd0);
        cycn(4'b0110, 80);
        chk("up_wrap_ledr", 32'(ledr_a), 32'd0);
        chk("up_wrap_tc", 32'(tc_a), 32'd1);
        cycn(4'b0110, 28);
        chk("up_seven", 32'(ledr_a), 32'd7);
        cycn(4'b0010, 4);
        chk("reverse_six", 32'(ledr_a), 32'd6);

        // async reset mid-interval at 3
        cycn(4'b0010, 14);
        chk("at_three", 32'(ledr_a), 32'd3);
        async_reset();
        chk("after_rst", 32'(ledr_a), 32'd19);

        // enable dropped at prescaler=2 discards the partial interval
        cycn(4'b0010, 2);
        cyc(4'b0000);
        cycn(4'b0010, 3);
        chk("pause_hold", 32'(ledr_a), 32'd19);
        cyc(4'b0010);
        chk("pause_step", 32'(ledr_a), 32'd18);

        // load coincident with tick at LEDR=5
        cycn(4'b0010, 52);
        chk("at_five", 32'(ledr_a), 32'd5);
        cycn(4'b0010, 3);
        cyc(4'b0011);
        chk("load_tick_ledr", 32'(ledr_a), 32'd19);
        chk("load_tick_tc", 32'(tc_a), 32'd0);

        // DIV=1, PRESET=0 instance: terminal every enabled cycle
        cyc(4'b0011);
        for (int i = 0; i < 8; i++) begin
            cyc(4'b0010);
            chk("div1_ledr", 32'(ledr_b), 32'd0);
            chk("div1_tc", 32'(tc_b), 32'd1);
        end
        cyc(4'b0000);
        chk("div1_idle_tc", 32'(tc_b), 32'd0);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            rs = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) != 0) rs[0] = 1'b0;
            if ($urandom_range(0, 5) != 0) rs[1] = 1'b1;
            cyc(rs);
            if ($urandom_range(0, 59) == 0) async_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
